// File: rtl/puneh_datapath_v2_pkg.sv
// Shared types for the PUNEH v2 datapath: op encodings, FSM states, SR bit positions.
package puneh_v2_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_LDM   = 4'h2,
        OP_STM   = 4'h3,
        OP_ADDI  = 4'h4,
        OP_ADDM  = 4'h5,
        OP_MULM  = 4'h6,
        OP_ANDM  = 4'h7,
        OP_NOT   = 4'h8,
        OP_SHL   = 4'h9,
        OP_SHR   = 4'hA,
        OP_JMP   = 4'hB,
        OP_CLR   = 4'hC,
        OP_SETSR = 4'hD
    } op_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

    localparam int unsigned FLG_Z = 3;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    function automatic logic is_mem_op(input op_code_e op);
        return op inside {OP_LDM, OP_STM, OP_ADDM, OP_MULM, OP_ANDM};
    endfunction

    // A flag contributes only if it is observed and matches its expected value.
    function automatic logic skip_cond(input logic [3:0] sr, input logic [3:0] exp_f,
                                       input logic [3:0] obs);
        return |(obs & ~(sr ^ exp_f));
    endfunction

endpackage

// File: rtl/puneh_datapath_v2_if.sv
// Controller op channel and memory req/ack channel of the PUNEH v2 datapath.
interface puneh_datapath_v2_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned NUM_AC = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_AC);

    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op_code;
    logic [SEL_W-1:0]  ac_sel;
    logic [DATA_W-1:0] imm;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // master: controller plus memory; slave: the datapath
    modport master (
        output op_valid, op_code, ac_sel, imm, mem_rdata, mem_ack,
        input  op_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  op_valid, op_code, ac_sel, imm, mem_rdata, mem_ack,
        output op_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/puneh_datapath_v2_seq_mul.sv
// Sequential shift-add multiplier: start loads and performs the first partial product,
// the remaining DATA_W-1 steps follow, done pulses for one cycle with prod valid.
module puneh_seq_mul #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   prod
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] prod_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                prod_q   <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
                mcand_q  <= {{(DATA_W-1){1'b0}}, a, 1'b0};
                mplier_q <= {1'b0, b[DATA_W-1:1]};
                cnt_q    <= CNT_W'(DATA_W - 1);
            end else if (cnt_q != '0) begin
                if (mplier_q[0]) begin
                    prod_q <= prod_q + mcand_q;
                end
                mcand_q  <= {mcand_q[2*DATA_W-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[DATA_W-1:1]};
                cnt_q    <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign prod = prod_q;

endmodule

// File: rtl/puneh_datapath_v2.sv
// PUNEH v2 datapath: accumulator bank, PC and Z/N/C/V status, driven by a valid/ready
// op channel, with a req/ack memory port and a multi-cycle multiplier.
module puneh_datapath_v2
    import puneh_v2_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned NUM_AC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    puneh_datapath_v2_if.slave    bus,
    input  logic [3:0]            skip_exp,
    input  logic [3:0]            skip_obs,
    output logic                  en_skp,
    output logic [ADDR_W-1:0]     pc_out,
    output logic [3:0]            sr_out,
    output logic                  busy
);
    localparam int unsigned SEL_W = $clog2(NUM_AC);

    state_e             state_q;
    op_code_e           op_q;
    logic [SEL_W-1:0]   sel_q;
    logic [DATA_W-1:0]  ac_q [NUM_AC];
    logic [ADDR_W-1:0]  pc_q;
    logic [3:0]         sr_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;

    op_code_e           cur_op;
    logic [SEL_W-1:0]   cur_sel;
    logic [DATA_W-1:0]  x_op;
    logic [DATA_W-1:0]  y_op;
    logic [DATA_W:0]    sum;
    logic [DATA_W-1:0]  res_d;
    logic [3:0]         sr_d;
    logic               ac_we;
    logic               set_zn;
    logic               accept;
    logic               ack_hit;
    logic               retire;
    logic               mul_start;
    logic               mul_done;
    logic [2*DATA_W-1:0] mul_prod;

    assign accept    = (state_q == ST_IDLE) && bus.op_valid;
    assign ack_hit   = (state_q == ST_MEM) && mem_req_q && bus.mem_ack;
    assign mul_start = ack_hit && (op_q == OP_MULM);
    assign retire    = (accept && !is_mem_op(cur_op))
                    || (ack_hit && (op_q != OP_MULM))
                    || ((state_q == ST_MUL) && mul_done);

    // In IDLE the live op fields drive the ALU; afterwards the latched ones do.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_op  = op_code_e'(bus.op_code);
            cur_sel = bus.ac_sel;
            y_op    = bus.imm;
        end else begin
            cur_op  = op_q;
            cur_sel = sel_q;
            y_op    = bus.mem_rdata;
        end
        x_op   = ac_q[cur_sel];
        sum    = {1'b0, x_op} + {1'b0, y_op};
        res_d  = x_op;
        sr_d   = sr_q;
        ac_we  = 1'b0;
        set_zn = 1'b0;
        case (cur_op)
            OP_LDI, OP_LDM: begin
                res_d  = y_op;
                ac_we  = 1'b1;
                set_zn = 1'b1;
            end
            OP_ADDI, OP_ADDM: begin
                res_d       = sum[DATA_W-1:0];
                ac_we       = 1'b1;
                set_zn      = 1'b1;
                sr_d[FLG_C] = sum[DATA_W];
                sr_d[FLG_V] = (x_op[DATA_W-1] == y_op[DATA_W-1])
                           && (sum[DATA_W-1] != x_op[DATA_W-1]);
            end
            OP_ANDM: begin
                res_d  = x_op & y_op;
                ac_we  = 1'b1;
                set_zn = 1'b1;
            end
            OP_NOT: begin
                res_d  = ~x_op;
                ac_we  = 1'b1;
                set_zn = 1'b1;
            end
            OP_SHL: begin
                res_d       = {x_op[DATA_W-2:0], 1'b0};
                ac_we       = 1'b1;
                set_zn      = 1'b1;
                sr_d[FLG_C] = x_op[DATA_W-1];
            end
            OP_SHR: begin
                res_d       = {1'b0, x_op[DATA_W-1:1]};
                ac_we       = 1'b1;
                set_zn      = 1'b1;
                sr_d[FLG_C] = x_op[0];
            end
            OP_CLR: begin
                res_d = '0;
                ac_we = 1'b1;
            end
            OP_SETSR: begin
                sr_d = y_op[3:0];
            end
            OP_MULM: begin
                res_d       = mul_prod[DATA_W-1:0];
                ac_we       = 1'b1;
                set_zn      = 1'b1;
                sr_d[FLG_C] = 1'b0;
                sr_d[FLG_V] = |mul_prod[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
        if (set_zn) begin
            sr_d[FLG_Z] = ~|res_d;
            sr_d[FLG_N] = res_d[DATA_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            sel_q       <= '0;
            pc_q        <= '0;
            sr_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int unsigned i = 0; i < NUM_AC; i++) begin
                ac_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && is_mem_op(cur_op)) begin
                        state_q     <= ST_MEM;
                        op_q        <= cur_op;
                        sel_q       <= bus.ac_sel;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= (cur_op == OP_STM);
                        mem_addr_q  <= bus.imm[ADDR_W-1:0];
                        mem_wdata_q <= x_op;
                    end
                end
                ST_MEM: begin
                    if (ack_hit) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= (op_q == OP_MULM) ? ST_MUL : ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (retire) begin
                if (ac_we) begin
                    ac_q[cur_sel] <= res_d;
                end
                sr_q <= sr_d;
                pc_q <= (cur_op == OP_JMP) ? y_op[ADDR_W-1:0] : pc_q + ADDR_W'(1);
            end
        end
    end

    puneh_seq_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (ac_q[sel_q]),
        .b     (bus.mem_rdata),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    assign bus.op_ready  = (state_q == ST_IDLE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = (state_q != ST_IDLE);
    assign pc_out        = pc_q;
    assign sr_out        = sr_q;
    assign en_skp        = skip_cond(sr_q, skip_exp, skip_obs);

endmodule
